// File: rtl/serial_tx_param.sv
// serial_tx_param: parametrised serial frame transmitter.
// Sends start bit, DATA_W data bits LSB first, optional even parity,
// then STOP_BITS stop bits; each bit lasts CLKS_PER_BIT clocks.
// Optional parity bit enabled by defining SERIAL_TX_PARITY_EN.
// Ports:
//   clk      system clock (rising edge)
//   rst      asynchronous active-high reset
//   load     level request; rising edge starts a frame, low aborts
//   data_in  word captured at the start edge
//   out      serial line, idles high
//   busy     high from start bit through last stop bit
//   done     frame complete, held until load drops
module serial_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
        $error("serial_tx_param: DATA_W must be 1..32");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("serial_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [CW-1:0]     cyc, cyc_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic              load_q;
    logic              start;
    logic              bit_tick;
    logic              active;
`ifdef SERIAL_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign start    = load & ~load_q;
    assign bit_tick = (cyc == CYC_LAST);
    assign active   = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh     <= '0;
            cyc    <= '0;
            bcnt   <= '0;
            load_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            cyc    <= cyc_n;
            bcnt   <= bcnt_n;
            load_q <= load;
`ifdef SERIAL_TX_PARITY_EN
            par    <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cyc_n   = cyc;
        bcnt_n  = bcnt;
        out     = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        if (active) begin
            busy  = 1'b1;
            cyc_n = bit_tick ? '0 : cyc + 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = START;
                    sh_n    = data_in;
                    cyc_n   = '0;
                    bcnt_n  = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            START: begin
                out = 1'b0;
                if (bit_tick) state_n = DATA;
            end
            DATA: begin
                out = sh[0];
                if (bit_tick) begin
                    sh_n = sh >> 1;
                    if (bcnt == DATA_LAST) begin
                        bcnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                out = par;
                if (bit_tick) state_n = STOP;
            end
`endif
            STOP: begin
                // bcnt is reused to count stop bits
                if (bit_tick) begin
                    if (bcnt == STOP_LAST) begin
                        bcnt_n  = '0;
                        state_n = DONE;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (!load) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Dropping load mid-frame wins over any bit boundary
        if (active && !load) begin
            state_n = IDLE;
            cyc_n   = '0;
            bcnt_n  = '0;
        end
    end

endmodule
